// File: rtl/toggle_period_gen.sv
// Field-toggle generator: flips gen_toggle every period_cur+1 pix_clk cycles.
// Period updates take effect only at a toggle boundary or when the generator stops.
module toggle_period_gen #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             pix_clk,
  input  logic             pix_resetn,
  input  logic             enable,
  input  logic [CNT_W-1:0] period_in,
  input  logic             period_load,
  input  logic             err_clr,
  output logic             gen_toggle,
  output logic             gen_pulse,
  output logic             running,
  output logic [CNT_W-1:0] period_cur,
  output logic             pending,
  output logic             load_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cur;
  logic [CNT_W-1:0] r_shadow;
  logic             r_pending;
  logic             r_toggle;
  logic             r_pulse;
  logic             r_err;

  logic [0:0]       w_state_d;
  logic [CNT_W-1:0] w_cnt_d;
  logic [CNT_W-1:0] w_cur_d;
  logic [CNT_W-1:0] w_shadow_d;
  logic             w_pending_d;
  logic             w_toggle_d;
  logic             w_pulse_d;
  logic             w_err_d;

  logic w_load_ok;
  logic w_load_bad;
  logic w_boundary;

  assign w_load_ok  = period_load && (period_in != '0);
  assign w_load_bad = period_load && (period_in == '0);
  assign w_boundary = (r_state == ST_RUN) && (r_cnt == r_cur);

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_cur_d     = r_cur;
    w_shadow_d  = r_shadow;
    w_pending_d = r_pending;
    w_toggle_d  = r_toggle;
    w_pulse_d   = 1'b0;
    w_err_d     = r_err;

    // An illegal load wins over a simultaneous clear.
    if (w_load_bad) begin
      w_err_d = 1'b1;
    end else if (err_clr) begin
      w_err_d = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        w_cnt_d = '0;
        if (w_load_ok) begin
          w_cur_d = period_in;
        end
        if (enable && (r_cur != '0)) begin
          w_state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_boundary) begin
          w_cnt_d     = '0;
          w_toggle_d  = ~r_toggle;
          w_pulse_d   = 1'b1;
          w_pending_d = 1'b0;
          // A load landing on the boundary itself bypasses the shadow.
          if (w_load_ok) begin
            w_cur_d = period_in;
          end else if (r_pending) begin
            w_cur_d = r_shadow;
          end
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
          if (w_load_ok) begin
            w_shadow_d  = period_in;
            w_pending_d = 1'b1;
          end
        end

        if (!enable) begin
          w_state_d = ST_IDLE;
          w_cnt_d   = '0;
          if (!w_boundary) begin
            if (w_load_ok) begin
              w_cur_d = period_in;
            end else if (r_pending) begin
              w_cur_d = r_shadow;
            end
            w_pending_d = 1'b0;
          end
        end
      end
      default: begin
        w_state_d = ST_IDLE;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge pix_clk or negedge pix_resetn) begin
    if (!pix_resetn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cur     <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_toggle  <= 1'b0;
      r_pulse   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_cur     <= w_cur_d;
      r_shadow  <= w_shadow_d;
      r_pending <= w_pending_d;
      r_toggle  <= w_toggle_d;
      r_pulse   <= w_pulse_d;
      r_err     <= w_err_d;
    end
  end

  assign gen_toggle = r_toggle;
  assign gen_pulse  = r_pulse;
  assign running    = (r_state == ST_RUN);
  assign period_cur = r_cur;
  assign pending    = r_pending;
  assign load_err   = r_err;

endmodule

// File: tb/tb_toggle_period_gen.sv
// Bench for toggle_period_gen: directed scenarios then random traffic, checked against
// a model that tracks the absolute cycle of the next toggle edge.
module tb_toggle_period_gen;

  localparam int unsigned CNT_W = 32;

  logic             pix_clk;
  logic             pix_resetn;
  logic             enable;
  logic [CNT_W-1:0] period_in;
  logic             period_load;
  logic             err_clr;
  logic             gen_toggle;
  logic             gen_pulse;
  logic             running;
  logic [CNT_W-1:0] period_cur;
  logic             pending;
  logic             load_err;

  toggle_period_gen #(.CNT_W(CNT_W)) dut (
    .pix_clk    (pix_clk),
    .pix_resetn (pix_resetn),
    .enable     (enable),
    .period_in  (period_in),
    .period_load(period_load),
    .err_clr    (err_clr),
    .gen_toggle (gen_toggle),
    .gen_pulse  (gen_pulse),
    .running    (running),
    .period_cur (period_cur),
    .pending    (pending),
    .load_err   (load_err)
  );

  initial pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: m_next is the absolute edge index of the next toggle.
  longint unsigned cyc = 0;
  longint unsigned m_next = 0;
  bit              m_run, m_toggle, m_pulse, m_pending, m_err;
  logic [CNT_W-1:0] m_cur, m_shadow;

  task automatic model_reset();
    m_run = 0; m_toggle = 0; m_pulse = 0; m_pending = 0; m_err = 0;
    m_cur = '0; m_shadow = '0; m_next = 0;
  endtask

  task automatic model_edge();
    bit ok, bad, at_edge;
    logic [CNT_W-1:0] newp;
    ok  = period_load && (period_in != 0);
    bad = period_load && (period_in == 0);
    if (bad) m_err = 1;
    else if (err_clr) m_err = 0;
    m_pulse = 0;
    if (!m_run) begin
      newp = m_cur;
      if (ok) m_cur = period_in;
      if (enable && newp != 0) begin
        m_run  = 1;
        m_next = cyc + m_cur + 1;
      end
    end else begin
      at_edge = (cyc == m_next);
      if (at_edge) begin
        m_toggle = ~m_toggle;
        m_pulse  = 1;
        newp = ok ? period_in : (m_pending ? m_shadow : m_cur);
        m_cur = newp;
        m_pending = 0;
        m_next = cyc + newp + 1;
      end else if (ok) begin
        m_shadow  = period_in;
        m_pending = 1;
      end
      if (!enable) begin
        m_run = 0;
        if (m_pending) m_cur = m_shadow;
        m_pending = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [CNT_W-1:0] obs,
                       input logic [CNT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    check("gen_toggle", CNT_W'(gen_toggle), CNT_W'(m_toggle));
    check("gen_pulse",  CNT_W'(gen_pulse),  CNT_W'(m_pulse));
    check("running",    CNT_W'(running),    CNT_W'(m_run));
    check("period_cur", period_cur,         m_cur);
    check("pending",    CNT_W'(pending),    CNT_W'(m_pending));
    check("load_err",   CNT_W'(load_err),   CNT_W'(m_err));
  endtask

  task automatic tick();
    @(posedge pix_clk);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(input logic [CNT_W-1:0] p);
    period_load = 1'b1;
    period_in   = p;
    tick();
    period_load = 1'b0;
  endtask

  // Advance until the next edge is a toggle boundary (bounded).
  task automatic to_boundary();
    int n;
    n = 0;
    while ((cyc + 1 != m_next) && n < 100) begin
      tick();
      n++;
    end
    check("boundary_reached", CNT_W'(cyc + 1 == m_next), CNT_W'(1));
  endtask

  initial begin
    pix_resetn = 1'b0; enable = 1'b0; period_in = '0; period_load = 1'b0; err_clr = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge pix_clk);
    @(negedge pix_clk);
    pix_resetn = 1'b1;

    // P=4: flips every 5 clocks.
    load(4);
    enable = 1'b1;
    ticks(17);

    // Stop, load P=9 in idle, run, then load P=2 mid-interval.
    enable = 1'b0;
    tick();
    load(9);
    enable = 1'b1;
    ticks(12);
    load(2);
    check("pending_after_load", CNT_W'(pending), CNT_W'(1));
    ticks(15);

    // Load on the exact boundary cycle of a P=3 stream.
    load(3);
    ticks(12);
    to_boundary();
    load(6);
    ticks(16);

    // Illegal loads and error clear.
    load(0);
    check("err_set", CNT_W'(load_err), CNT_W'(1));
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_cleared", CNT_W'(load_err), CNT_W'(0));
    err_clr = 1'b1; load(0); err_clr = 1'b0;
    check("err_clr_vs_bad", CNT_W'(load_err), CNT_W'(1));
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Stop with pending shadow 7, then restart.
    ticks(2);
    load(7);
    enable = 1'b0;
    tick();
    check("stop_applies_shadow", period_cur, 7);
    ticks(3);
    enable = 1'b1;
    ticks(20);

    // Asynchronous reset mid-run with gen_toggle high.
    for (int i = 0; i < 40 && !m_toggle; i++) tick();
    check("toggle_high_before_reset", CNT_W'(gen_toggle), CNT_W'(1));
    #2;
    pix_resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge pix_clk);
    pix_resetn = 1'b1;
    enable = 1'b1;
    ticks(5);
    check("idle_with_zero_period", CNT_W'(running), CNT_W'(0));

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      enable      = ($urandom_range(0, 19) != 0);
      period_load = enable && ($urandom_range(0, 7) == 0);
      period_in   = CNT_W'($urandom_range(0, 6));
      err_clr     = ($urandom_range(0, 15) == 0);
      tick();
    end
    period_load = 1'b0;
    err_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/toggle_period_gen.md
# toggle_period_gen

Single-clock field-toggle generator in the pix domain: emits a toggle edge every programmed number of pix_clk cycles, acting as the sending end of the toggle-period measurement path. The period value uses the same encoding as the measurer's latched count (value P means toggle edges spaced P+1 clocks apart), so a measured period fed back in reproduces the measured cadence. Used to drive a synthetic or flywheel field toggle when the camera field toggle is absent. Period updates are glitch-free: they apply only at a toggle boundary.

## Interface
- CNT_W, 32, width of period value and internal counter
- pix_clk  in  1  clock
- pix_resetn  in  1  asynchronous, active-low reset (the only reset; one clock domain)
- enable  in  1  level; high = run, low = stop
- period_in  in  CNT_W  period value P (edge spacing = P+1 clocks); P = 0 illegal
- period_load  in  1  1-clk pulse, samples period_in
- err_clr  in  1  1-clk pulse, clears load_err
- gen_toggle  out  1  generated toggle, flips once per period
- gen_pulse  out  1  1-clk pulse in the cycle gen_toggle changes
- running  out  1  high in RUN state
- period_cur  out  CNT_W  period value currently in use
- pending  out  1  shadow period waiting for next boundary
- load_err  out  1  sticky: a load of P = 0 was rejected

## Operation
- Reset: all outputs 0, internal counter 0, shadow 0, state IDLE.
- States: IDLE, RUN.
- IDLE: counter held 0. Valid period_load (P ≥ 1) writes period_cur directly next clock, pending stays 0. enable high and period_cur ≠ 0 → RUN next clock with counter 0. enable high and period_cur = 0 → remain IDLE, no error.
- RUN: counter increments by 1 each clock. Boundary = cycle where counter == period_cur: counter ← 0, gen_toggle flips, gen_pulse = 1 for that clock. If pending, period_cur ← shadow and pending ← 0 at the same edge.
- Load in RUN: shadow ← period_in, pending ← 1. Load sampled in a boundary cycle applies at that same boundary (period_cur ← period_in directly, pending stays 0). Multiple loads before a boundary: last wins.
- Load with period_in = 0 in any state: ignored (period_cur, shadow, pending unchanged), load_err ← 1. err_clr clears load_err; if err_clr and an illegal load coincide, load_err = 1.
- enable low in RUN → IDLE next clock. Counter ← 0; a pending shadow is applied to period_cur and pending ← 0; gen_toggle holds its level; no gen_pulse. A boundary in the same cycle as enable falling still toggles.
- Counter arithmetic is CNT_W bits. period_cur ≤ 2^CNT_W − 1, so the counter reaches the boundary before it wraps.
- Asynchronous reset mid-RUN: immediate return to reset values, including gen_toggle = 0.

## Timing
- All outputs registered. gen_toggle and gen_pulse change on the same pix_clk edge.
- enable sampled high at edge E0 (IDLE, period_cur = P) → running = 1 after E0. First gen_toggle flip at edge E0+P+1, then every P+1 edges.
- period_load at edge L in IDLE → period_cur valid after L.
- period_load in RUN → pending = 1 after L. New period takes effect for the interval starting at the next boundary, so the interval in progress keeps its old length.
- Round trip: with the measurer on the same clock, a steady output yields latched count = period_cur.

## Test plan
- Reset, load P=4, enable → running after 1 clk. gen_toggle flips at E0+5, E0+10, E0+15. gen_pulse is 1 clk wide on exactly those edges.
- Running at P=9, load P=2 mid-interval → pending = 1. Current interval stays 10 clocks, following intervals are 3 clocks, pending clears at the boundary.
- Load P=6 in the exact boundary cycle of a P=3 stream → the next interval is 7 clocks and pending never asserts.
- Load P=0 → load_err = 1, period_cur unchanged. err_clr → 0. Simultaneous err_clr and P=0 load → load_err stays 1.
- enable low with pending shadow 7 → IDLE next clock, period_cur = 7, gen_toggle level held. Re-enable → first flip 8 clocks later.
- Assert pix_resetn low mid-RUN with gen_toggle = 1 → all outputs 0 immediately. After release, enable with period_cur = 0 keeps the block in IDLE.
